// File: rtl/bus_arbiter_8.sv
// bus_arbiter_8: round-robin owner selection for an 8-input shared-bus mux.
// Drives one-hot gnt_o, the mux select sel_o and enable bus_en_o from registers.
// A hold limit (MAX_HOLD) bounds ownership while another requester waits.
// Optional build macro BUS_ARB_TURNAROUND_EN inserts one idle GAP cycle between
// owners so the tri-stated bus is never driven by two requesters at a hand-off.
module bus_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 4   // legal 1..255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       bus_en_o,
    output logic       preempt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
`ifdef BUS_ARB_TURNAROUND_EN
    localparam logic [1:0] ST_GAP  = 2'd2;
`endif

    // Last hold count value; reaching it while others wait ends the grant.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [7:0] hold_q,  hold_d;
    logic [7:0] gnt_q,   gnt_d;
    logic [2:0] sel_q,   sel_d;
    logic       en_q,    en_d;
    logic       pre_q,   pre_d;

    // Rotated priority search: returns {found, index}, first set bit at or after p.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        // Walk from farthest offset down so the nearest request is kept last.
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [3:0] pick_ptr;    // winner when arbitrating from IDLE/GAP
    logic [3:0] pick_rel;    // winner searched from owner+1 at a release
    logic [2:0] ptr_rel;     // pointer value once the current owner lets go
    logic       others;      // some requester other than the owner is waiting
    logic       rel_norm;    // owner dropped its request
    logic       rel_pre;     // hold limit reached under contention

    // Release-side arbitration terms, all from sampled req and current owner.
    always_comb begin
        ptr_rel  = sel_q + 3'd1;
        pick_ptr = rr_pick(req_i, ptr_q);
        pick_rel = rr_pick(req_i, ptr_rel);
        others   = |(req_i & ~gnt_q);
        rel_norm = ~req_i[sel_q];
        rel_pre  = req_i[sel_q] & (hold_q == HOLD_LAST) & others;
    end

    // Next-state logic for the owner FSM and its registered outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        pre_d   = 1'b0;
        case (state_q)
            ST_OWN: begin
                if (rel_norm || rel_pre) begin
                    ptr_d = ptr_rel;
                    pre_d = rel_pre;
`ifdef BUS_ARB_TURNAROUND_EN
                    // Always park the bus for one cycle; sel keeps its value.
                    state_d = ST_GAP;
                    gnt_d   = 8'd0;
                    en_d    = 1'b0;
`else
                    // Back-to-back hand-off; owner sits last in the new order.
                    if (pick_rel[3]) begin
                        gnt_d  = 8'd1 << pick_rel[2:0];
                        sel_d  = pick_rel[2:0];
                        en_d   = 1'b1;
                        hold_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 8'd0;
                        en_d    = 1'b0;
                    end
`endif
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically from the stored pointer.
                if (pick_ptr[3]) begin
                    state_d = ST_OWN;
                    gnt_d   = 8'd1 << pick_ptr[2:0];
                    sel_d   = pick_ptr[2:0];
                    en_d    = 1'b1;
                    hold_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 8'd0;
                    en_d    = 1'b0;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            pre_q   <= pre_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign bus_en_o  = en_q;
    assign preempt_o = pre_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// tb_bus_arbiter_8: scoreboard bench. The driver applies req/rst at the falling
// edge, advances an ownership-level reference model and queues the outputs it
// expects after the next rising edge; a monitor pops and compares after each
// rising edge. Honors BUS_ARB_TURNAROUND_EN the same way the design does.
module tb_bus_arbiter_8;

    localparam int MH = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] req_i = 8'd0;
    logic [7:0] gnt_o;
    logic [2:0] sel_o;
    logic       bus_en_o;
    logic       preempt_o;

    bus_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
        .gnt_o(gnt_o), .sel_o(sel_o), .bus_en_o(bus_en_o), .preempt_o(preempt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       en;
        logic       pre;
        bit         chk_sel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the bus, for how many cycles, and where the
    // rotated search starts next time.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_held  = 0;
    logic [2:0] m_sel   = 3'd0;
    bit         m_fresh = 1'b1;   // no grant since reset: sel known to be 0

    function automatic int find_first(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    // Advance the model by one rising edge with the given inputs and queue result.
    task automatic model_edge(input logic r, input logic [7:0] q);
        exp_t e;
        bit   pre;
        bit   others;
        int   w;
        pre = 1'b0;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 3'd0; m_fresh = 1'b1;
        end else if (m_owner < 0) begin
            w = find_first(q, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_held = 1; m_sel = 3'(w); m_fresh = 1'b0;
            end
        end else begin
            others = 1'b0;
            for (int j = 0; j < 8; j++) if (j != m_owner && q[j]) others = 1'b1;
            if (!q[m_owner] || (m_held >= MH && others)) begin
                pre   = q[m_owner];
                m_ptr = (m_owner + 1) % 8;
`ifdef BUS_ARB_TURNAROUND_EN
                m_owner = -1;
`else
                w = find_first(q, m_ptr);
                m_owner = w;
                if (w >= 0) begin
                    m_held = 1; m_sel = 3'(w);
                end
`endif
            end else begin
                m_held++;
            end
        end
        e.gnt     = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.en      = (m_owner >= 0);
        e.sel     = m_sel;
        e.pre     = pre;
        e.chk_sel = e.en || m_fresh;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [7:0] q);
        @(negedge clk_i);
        rst_i = r;
        req_i = q;
        model_edge(r, q);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare after every rising edge for which an expectation exists.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt", gnt_o, e.gnt);
                chk("bus_en", bus_en_o, e.en);
                chk("preempt", preempt_o, e.pre);
                if (e.chk_sel) chk("sel", sel_o, e.sel);
                chk("bus_en_eq_or_gnt", bus_en_o, |gnt_o);
                chk("gnt_onehot0", $onehot0(gnt_o), 1);
            end
        end
    end

    initial begin
        logic [7:0] q;
        int         guard;
        // Reset then idle.
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        repeat (3) step(1'b0, 8'h00);
        // Single requester held with no contention, then dropped.
        repeat (11) step(1'b0, 8'h08);
        repeat (2) step(1'b0, 8'h00);
        // Contention between 0 and 7: hold limit alternation.
        repeat (20) step(1'b0, 8'h81);
        repeat (2) step(1'b0, 8'h00);
        // Wrap-around: 7 owns, then releases into 8'h41.
        repeat (3) step(1'b0, 8'h80);
        repeat (10) step(1'b0, 8'h41);
        repeat (2) step(1'b0, 8'h00);
        // Adjacent pair (turnaround visible when the macro is set).
        repeat (12) step(1'b0, 8'h03);
        repeat (2) step(1'b0, 8'h00);
        // Reset in the middle of a grant, request kept high.
        repeat (4) step(1'b0, 8'h20);
        step(1'b1, 8'h20);
        repeat (4) step(1'b0, 8'h20);
        // Randomized traffic with persistent request levels and rare resets.
        q = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) q[b] = ~q[b];
            step($urandom_range(199) == 0, q);
        end
        step(1'b0, 8'h00);
        // Drain with a bounded wait.
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk_i);
            guard++;
        end
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_8.md
# bus_arbiter_8

Round-robin arbiter that shares one 8-input shared-bus multiplexer among eight requesters. Each cycle it decides which requester owns the bus and drives the multiplexer's 3-bit select and enable directly, so a single owner drives the bus at a time. A hold limit bounds ownership under contention. An optional dead cycle between owners keeps the tri-stated bus undriven across hand-offs.

## Interface
- MAX_HOLD, 4: maximum consecutive owned cycles while another requester is waiting; legal range 1..255.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  per-requester bus request; level, held high while the bus is wanted.
- gnt  out  8  one-hot grant; all-zero when no owner.
- sel  out  3  multiplexer select = index of current owner.
- bus_en  out  1  multiplexer enable; high exactly when gnt is non-zero.
- preempt  out  1  one-cycle pulse: the current grant was removed by the hold limit.

## Operation
- All outputs registered. Reset values: gnt=0, sel=0, bus_en=0, preempt=0; internal pointer ptr=0, hold count=0, state IDLE.
- Priority: search starts at index ptr and wraps (ptr, ptr+1, …, 7, 0, …, ptr-1); first asserted req wins. ptr is set to owner+1 mod 8 (7 wraps to 0) whenever a grant ends.
- States: IDLE, OWN, GAP (GAP exists only with the macro).
- IDLE: gnt=0, bus_en=0. If req≠0 → OWN with winner w: gnt=1<<w, sel=w, bus_en=1, hold count=0.
- OWN, each cycle: hold count increments, saturating at MAX_HOLD-1.
- OWN release on req[owner]=0 (normal), or on hold count==MAX_HOLD-1 while some other req bit is high (preempt; preempt=1 for one cycle, aligned with the cycle gnt drops or changes).
- Hold limit with no other requester: no preemption; owner keeps the bus indefinitely.
- Release without macro: if any req remains (owner excluded by rotated priority unless it is the only one), grant the next winner in the same edge; otherwise → IDLE.
- Release with macro: → GAP.
- GAP: gnt=0, bus_en=0, sel holds the last value. Arbitrate next cycle as in IDLE.
- A requester that drops req while not owner is never granted. Requests asserted and dropped between edges are lost.
- gnt always has at most one bit set. bus_en==|gnt. sel==index of gnt when bus_en=1.

## Timing
- Grant latency: req rising sampled at edge k → gnt/bus_en high after edge k. One cycle from IDLE; two cycles from release with the macro.
- Release latency: req[owner] low sampled at edge k → gnt bit cleared after edge k.
- Preempted owner holds the bus for exactly MAX_HOLD cycles; MAX_HOLD=1 gives one-cycle alternation under contention.
- Simultaneous release and new requests: all resolved at one edge using the updated ptr.
- rst high at any edge, including mid-grant or in GAP, forces reset values after that edge. req is ignored during rst.

## Configuration
- BUS_ARB_TURNAROUND_EN defined: GAP state compiled in. One cycle with bus_en=0 and gnt=0 separates every pair of owners, including preemption hand-offs.
- Not defined: no GAP state. Hand-off is back-to-back: gnt moves between owners in one edge and bus_en stays high.

## Test plan
- Reset then idle: rst=1 for 2 cycles, req=0 → gnt=0, sel=0, bus_en=0, preempt=0 throughout.
- Single requester: req=8'h08 at cycle 0 → gnt=8'h08, sel=3, bus_en=1 from cycle 1. Held 10 cycles with no preempt. req=0 → bus_en=0 next cycle.
- Round robin, MAX_HOLD=4, no macro: req=8'h81 held → owner 0 for 4 cycles, preempt pulse, owner 7 for 4 cycles, back to 0. sel alternates 0/7.
- Wrap-around: owner 7 releases with req=8'h41 → next owner 0 (ptr wrapped), then 6.
- Turnaround, macro defined: req=8'h03 → owner 0 for MAX_HOLD cycles, one cycle bus_en=0, then owner 1.
- Reset mid-grant: owner 5 active, rst=1 for 1 cycle → all outputs 0 next cycle. With req still 8'h20, owner 5 is re-granted one cycle after rst falls (ptr=0).
